bc_arbiter: RTL and testbench
=============================

BC_ARBITER -- requirements
Module: bc_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, the maximum number of words accepted per grant (range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports avoid_in_data  input  16, avoid_in_valid  input  1, avoid_in_rdy  output  1: the avoidance source stream (source 0).
REQ-005 SHALL have ports pwm_in_data  input  16, pwm_in_valid  input  1, pwm_in_rdy  output  1: the PWM source stream (source 1).
REQ-006 SHALL have ports buf_out_data  output  16, buf_out_valid  output  1, buf_out_rdy  input  1: the merged stream into the breadcrumb buffer write side.
REQ-007 SHALL have port buf_out_src  output  1: source id of the word on buf_out_data (0 = avoid, 1 = pwm).
REQ-008 SHALL have port stat_clr  input  1: synchronous clear of both word counters.
REQ-009 SHALL have ports avoid_count and pwm_count  output  16 each: words accepted per source.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT_AVOID, GRANT_PWM.
REQ-011 IDLE: if exactly one source is valid, SHALL go to that source's GRANT state; if both are valid, SHALL grant the source not served last (rr pointer); otherwise SHALL stay in IDLE.
REQ-012 A source handshake ("accept") SHALL occur when the source is granted, its valid is high and its rdy is high.
REQ-013 src_rdy SHALL be high only in that source's GRANT state with (!buf_out_valid || buf_out_rdy); the non-granted rdy SHALL be low, and rdy SHALL be low in IDLE.
REQ-014 SHALL count accepts in an 8-bit burst_cnt, cleared on entry to any GRANT state.
REQ-015 Exit from GRANT_x SHALL occur on (accept && burst_cnt == MAX_BURST-1) or on !x_valid.
REQ-016 On exit, next state SHALL be the other GRANT if the other source's valid is high in the exit cycle.
REQ-017 If the other source is not valid, next state SHALL be GRANT_x again (fresh burst) when the exit was a burst exhaustion with x_valid high.
REQ-018 In all remaining exit cases, next state SHALL be IDLE.
REQ-019 rr pointer SHALL record the source of every GRANT exit.
REQ-020 Output SHALL be a one-entry register stage; accept loads data and source id and sets buf_out_valid in the next cycle, so latency is 1 cycle.
REQ-021 Without an accept, buf_out_valid SHALL clear when buf_out_rdy is high; data and source id SHALL hold while valid is high and rdy is low.
REQ-022 Full throughput (1 word/cycle) SHALL be sustained while buf_out_rdy is high; there is one bubble per IDLE visit.
REQ-023 avoid_count and pwm_count SHALL increment by 1 per accept of their source and wrap 0xFFFF to 0x0000.
REQ-024 stat_clr SHALL win over a simultaneous increment: the counter becomes 0.
REQ-025 Source valid dropping while granted SHALL never lose an accepted word.

Reset
REQ-026 While rst is low, SHALL force: state IDLE, rr pointer such that avoid wins the first tie, burst_cnt 0, buf_out_valid 0, buf_out_data 0x0000, buf_out_src 0, both counters 0, both rdy 0.
REQ-027 Reset asserted mid-burst SHALL discard the registered word; no accept SHALL occur in the first cycle after deassertion (state IDLE).

Structure
REQ-028 A shared package bc_pkg SHALL hold the FSM state enum (bc_arb_state_t), the source id type/constants (BC_SRC_AVOID = 0, BC_SRC_PWM = 1) and the data width constant BC_WIDTH = 16.
REQ-029 The output register stage SHALL be a sub-module bc_reg_slice (16-bit data + 1-bit tag, valid/ready); arbitration and counters stay in bc_arbiter.

Verification
REQ-030 Reset release, avoid sends 0x0001..0x0003, buf_out_rdy = 1 -> buf_out sees 0x0001..0x0003, src 0, each 1 cycle after its accept; avoid_count = 3.
REQ-031 Both sources continuously valid, MAX_BURST = 8, buf_out_rdy = 1 -> 8 avoid words, then 8 pwm words, alternating, with no bubble between bursts.
REQ-032 Only pwm valid for 20 words -> bursts of 8, 8, 4 back-to-back; pwm_count = 20; avoid_rdy stays 0.
REQ-033 buf_out_rdy held low for 5 cycles mid-stream -> buf_out_data/src stable, granted rdy low, no words lost or duplicated after release.
REQ-034 pwm_count preset to 0xFFFF by 65535 accepts, then one more accept -> pwm_count = 0x0000; stat_clr together with an accept -> counter = 0.
REQ-035 rst asserted in the 3rd word of an avoid burst -> all outputs at reset values immediately; after release with both valid -> avoid granted first.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared types and constants for the breadcrumb arbiter slice.
package bc_pkg;

    localparam int unsigned BC_WIDTH = 16;

    typedef logic bc_src_t;
    localparam bc_src_t BC_SRC_AVOID = 1'b0;
    localparam bc_src_t BC_SRC_PWM   = 1'b1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_AVOID = 2'd1,
        GRANT_PWM   = 2'd2
    } bc_arb_state_t;

endpackage

// File: rtl/bc_reg_slice.sv
// One-entry valid/ready register stage carrying a data word and a source tag.
module bc_reg_slice
    import bc_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [BC_WIDTH-1:0] i_data,
    input  bc_src_t             i_tag,
    input  logic                i_rdy,
    output logic [BC_WIDTH-1:0] o_data,
    output bc_src_t             o_tag,
    output logic                o_valid
);

    logic [BC_WIDTH-1:0] r_data;
    bc_src_t             r_tag;
    logic                r_valid;

    // Data and tag only move on a load, so they hold through backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_tag   <= BC_SRC_AVOID;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_tag   <= i_tag;
            r_valid <= 1'b1;
        end else if (i_rdy) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_tag   = r_tag;
    assign o_valid = r_valid;

endmodule

// File: rtl/bc_arbiter.sv
// Round-robin burst arbiter merging the avoidance and PWM streams into the
// breadcrumb buffer, with per-source accepted-word counters.
module bc_arbiter
    import bc_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BC_WIDTH-1:0] avoid_in_data,
    input  logic                avoid_in_valid,
    output logic                avoid_in_rdy,
    input  logic [BC_WIDTH-1:0] pwm_in_data,
    input  logic                pwm_in_valid,
    output logic                pwm_in_rdy,
    output logic [BC_WIDTH-1:0] buf_out_data,
    output logic                buf_out_valid,
    input  logic                buf_out_rdy,
    output logic                buf_out_src,
    input  logic                stat_clr,
    output logic [15:0]         avoid_count,
    output logic [15:0]         pwm_count
);

    localparam logic [7:0] LP_LAST = 8'(MAX_BURST - 1);

    bc_arb_state_t       r_state;
    bc_arb_state_t       w_next;
    bc_src_t             r_last;
    logic [7:0]          r_burst;
    logic [15:0]         r_avoid_cnt;
    logic [15:0]         r_pwm_cnt;
    logic                w_can;
    logic                w_acc_avoid;
    logic                w_acc_pwm;
    logic                w_accept;
    logic                w_exhaust;
    logic                w_exit;
    logic [BC_WIDTH-1:0] w_data;
    bc_src_t             w_src;

    assign w_can       = !buf_out_valid || buf_out_rdy;
    assign w_acc_avoid = avoid_in_rdy && avoid_in_valid;
    assign w_acc_pwm   = pwm_in_rdy && pwm_in_valid;
    assign w_accept    = w_acc_avoid || w_acc_pwm;
    assign w_exhaust   = w_accept && (r_burst == LP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_exit = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (avoid_in_valid && pwm_in_valid) begin
                    w_next = (r_last == BC_SRC_AVOID) ? GRANT_PWM : GRANT_AVOID;
                end else if (avoid_in_valid) begin
                    w_next = GRANT_AVOID;
                end else if (pwm_in_valid) begin
                    w_next = GRANT_PWM;
                end
            end
            GRANT_AVOID: begin
                if (w_exhaust || !avoid_in_valid) begin
                    w_exit = 1'b1;
                    if (pwm_in_valid) begin
                        w_next = GRANT_PWM;
                    end else if (w_exhaust && avoid_in_valid) begin
                        w_next = GRANT_AVOID;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            GRANT_PWM: begin
                if (w_exhaust || !pwm_in_valid) begin
                    w_exit = 1'b1;
                    if (avoid_in_valid) begin
                        w_next = GRANT_AVOID;
                    end else if (w_exhaust && pwm_in_valid) begin
                        w_next = GRANT_PWM;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        avoid_in_rdy = (r_state == GRANT_AVOID) && w_can;
        pwm_in_rdy   = (r_state == GRANT_PWM) && w_can;
        w_data       = (r_state == GRANT_PWM) ? pwm_in_data : avoid_in_data;
        w_src        = (r_state == GRANT_PWM) ? BC_SRC_PWM : BC_SRC_AVOID;
    end

    // Reset to PWM as last-served so avoid wins the first tie; burst count
    // restarts on every grant exit, which also covers a same-source re-grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last  <= BC_SRC_PWM;
            r_burst <= '0;
        end else begin
            if (w_exit) begin
                r_last <= (r_state == GRANT_PWM) ? BC_SRC_PWM : BC_SRC_AVOID;
            end
            if (r_state == IDLE || w_exit) begin
                r_burst <= '0;
            end else if (w_accept) begin
                r_burst <= r_burst + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_avoid_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            if (stat_clr) begin
                r_avoid_cnt <= '0;
                r_pwm_cnt   <= '0;
            end else begin
                if (w_acc_avoid) r_avoid_cnt <= r_avoid_cnt + 16'd1;
                if (w_acc_pwm)   r_pwm_cnt   <= r_pwm_cnt + 16'd1;
            end
        end
    end

    assign avoid_count = r_avoid_cnt;
    assign pwm_count   = r_pwm_cnt;

    bc_reg_slice u_out_slice (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_accept),
        .i_data  (w_data),
        .i_tag   (w_src),
        .i_rdy   (buf_out_rdy),
        .o_data  (buf_out_data),
        .o_tag   (buf_out_src),
        .o_valid (buf_out_valid)
    );

endmodule

// File: tb/tb_bc_arbiter.sv
// Directed self-checking bench for bc_arbiter.
module tb_bc_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] avoid_in_data = '0;
    logic        avoid_in_valid = 1'b0;
    logic        avoid_in_rdy;
    logic [15:0] pwm_in_data = '0;
    logic        pwm_in_valid = 1'b0;
    logic        pwm_in_rdy;
    logic [15:0] buf_out_data;
    logic        buf_out_valid;
    logic        buf_out_rdy = 1'b1;
    logic        buf_out_src;
    logic        stat_clr = 1'b0;
    logic [15:0] avoid_count;
    logic [15:0] pwm_count;

    int total = 0;
    int bad = 0;
    logic        mon_en = 1'b0;
    logic [16:0] q[$];

    bc_arbiter #(.MAX_BURST(8)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .avoid_in_data  (avoid_in_data),
        .avoid_in_valid (avoid_in_valid),
        .avoid_in_rdy   (avoid_in_rdy),
        .pwm_in_data    (pwm_in_data),
        .pwm_in_valid   (pwm_in_valid),
        .pwm_in_rdy     (pwm_in_rdy),
        .buf_out_data   (buf_out_data),
        .buf_out_valid  (buf_out_valid),
        .buf_out_rdy    (buf_out_rdy),
        .buf_out_src    (buf_out_src),
        .stat_clr       (stat_clr),
        .avoid_count    (avoid_count),
        .pwm_count      (pwm_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && rst_n && buf_out_valid && buf_out_rdy)
            q.push_back({buf_out_src, buf_out_data});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        avoid_in_valid = 1'b0;
        pwm_in_valid = 1'b0;
        buf_out_rdy = 1'b1;
        stat_clr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        q.delete();
        mon_en = 1'b1;
    endtask

    // Drives the enabled sources with incrementing data until n_total words are accepted.
    task automatic drive_stream(input bit en_a, input bit en_p, input int n_total,
                                input logic [15:0] base_a, input logic [15:0] base_p,
                                output int span, output int n_a, output int n_p,
                                output int leak_a);
        int c = 0;
        int first_c = -1;
        int last_c = -1;
        bit acc_a, acc_p;
        n_a = 0; n_p = 0; leak_a = 0;
        while ((n_a + n_p) < n_total && c < n_total * 4 + 20) begin
            avoid_in_valid = en_a;
            pwm_in_valid = en_p;
            avoid_in_data = base_a + 16'(n_a);
            pwm_in_data = base_p + 16'(n_p);
            #1;
            acc_a = avoid_in_rdy && en_a;
            acc_p = pwm_in_rdy && en_p;
            if (!en_a && avoid_in_rdy) leak_a++;
            tick();
            if (acc_a || acc_p) begin
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (acc_a) n_a++;
            if (acc_p) n_p++;
            c++;
        end
        avoid_in_valid = 1'b0;
        pwm_in_valid = 1'b0;
        span = (first_c < 0) ? 0 : last_c - first_c + 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        avoid_in_valid = 1'b1;
        pwm_in_valid = 1'b1;
        repeat (2) tick();
        total++; if (buf_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", buf_out_valid); end
        total++; if (buf_out_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", buf_out_data); end
        total++; if (buf_out_src !== 1'b0) begin bad++; $display("FAIL reset_src got=%b exp=0", buf_out_src); end
        total++; if (avoid_in_rdy !== 1'b0 || pwm_in_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b%b exp=00", avoid_in_rdy, pwm_in_rdy); end
        total++; if (avoid_count !== 16'h0 || pwm_count !== 16'h0) begin bad++; $display("FAIL reset_counts got=%h/%h exp=0000/0000", avoid_count, pwm_count); end
        avoid_in_valid = 1'b0;
        pwm_in_valid = 1'b0;
    endtask

    task automatic test_single_source;
        int budget;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            avoid_in_valid = 1'b1;
            avoid_in_data = 16'(i + 1);
            budget = 0;
            while (!avoid_in_rdy && budget < 10) begin tick(); budget++; end
            total++; if (avoid_in_rdy !== 1'b1) begin bad++; $display("FAIL single_rdy_wait word=%0d got=%b exp=1", i, avoid_in_rdy); end
            if (i == 0) begin
                total++; if (buf_out_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid got=%b exp=0", buf_out_valid); end
            end
            tick();
            total++;
            if (buf_out_valid !== 1'b1 || buf_out_data !== 16'(i + 1) || buf_out_src !== 1'b0) begin
                bad++; $display("FAIL single_word%0d got=v%b d%h s%b exp=v1 d%h s0", i, buf_out_valid, buf_out_data, buf_out_src, 16'(i + 1));
            end
        end
        avoid_in_valid = 1'b0;
        total++; if (avoid_count !== 16'd3) begin bad++; $display("FAIL single_count got=%0d exp=3", avoid_count); end
        tick();
        total++; if (buf_out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", buf_out_valid); end
        total++; if (avoid_in_rdy !== 1'b0) begin bad++; $display("FAIL single_idle_rdy got=%b exp=0", avoid_in_rdy); end
    endtask

    task automatic test_alternate;
        int span, n_a, n_p, leak;
        logic [16:0] exp;
        int blk;
        do_reset();
        drive_stream(1'b1, 1'b1, 32, 16'hA000, 16'hB000, span, n_a, n_p, leak);
        repeat (3) tick();
        total++; if (span !== 32) begin bad++; $display("FAIL alt_span got=%0d exp=32", span); end
        total++; if (q.size() !== 32) begin bad++; $display("FAIL alt_size got=%0d exp=32", q.size()); end
        for (int k = 0; k < 32 && k < q.size(); k++) begin
            blk = k / 8;
            exp[16] = blk[0];
            exp[15:0] = (blk[0] ? 16'hB000 : 16'hA000) + 16'((blk / 2) * 8 + k % 8);
            total++; if (q[k] !== exp) begin bad++; $display("FAIL alt_word%0d got=%h exp=%h", k, q[k], exp); end
        end
        total++; if (avoid_count !== 16'd16 || pwm_count !== 16'd16) begin bad++; $display("FAIL alt_counts got=%0d/%0d exp=16/16", avoid_count, pwm_count); end
    endtask

    task automatic test_pwm_only;
        int span, n_a, n_p, leak;
        do_reset();
        drive_stream(1'b0, 1'b1, 20, 16'h0000, 16'h7000, span, n_a, n_p, leak);
        repeat (3) tick();
        total++; if (leak !== 0) begin bad++; $display("FAIL pwm_avoid_rdy cycles_high=%0d exp=0", leak); end
        total++; if (span !== 20) begin bad++; $display("FAIL pwm_span got=%0d exp=20", span); end
        total++; if (pwm_count !== 16'd20) begin bad++; $display("FAIL pwm_count got=%0d exp=20", pwm_count); end
        total++; if (q.size() !== 20) begin bad++; $display("FAIL pwm_size got=%0d exp=20", q.size()); end
        for (int k = 0; k < 20 && k < q.size(); k++) begin
            total++; if (q[k] !== {1'b1, 16'h7000 + 16'(k)}) begin bad++; $display("FAIL pwm_word%0d got=%h exp=%h", k, q[k], {1'b1, 16'h7000 + 16'(k)}); end
        end
    endtask

    task automatic test_backpressure;
        int n = 0;
        int c = 0;
        bit acc;
        do_reset();
        while (n < 12 && c < 100) begin
            buf_out_rdy = !(c >= 5 && c < 10);
            avoid_in_valid = 1'b1;
            avoid_in_data = 16'hC000 + 16'(n);
            #1;
            acc = avoid_in_rdy;
            if (!buf_out_rdy) begin
                total++; if (avoid_in_rdy !== 1'b0) begin bad++; $display("FAIL bp_rdy cyc=%0d got=%b exp=0", c, avoid_in_rdy); end
                total++;
                if (buf_out_valid !== 1'b1 || {buf_out_src, buf_out_data} !== {1'b0, 16'hC000 + 16'(n - 1)}) begin
                    bad++; $display("FAIL bp_hold cyc=%0d got=v%b %h exp=v1 %h", c, buf_out_valid, {buf_out_src, buf_out_data}, {1'b0, 16'hC000 + 16'(n - 1)});
                end
            end
            tick();
            if (acc) n++;
            c++;
        end
        avoid_in_valid = 1'b0;
        buf_out_rdy = 1'b1;
        repeat (3) tick();
        total++; if (q.size() !== 12) begin bad++; $display("FAIL bp_size got=%0d exp=12", q.size()); end
        for (int k = 0; k < 12 && k < q.size(); k++) begin
            total++; if (q[k] !== {1'b0, 16'hC000 + 16'(k)}) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", k, q[k], {1'b0, 16'hC000 + 16'(k)}); end
        end
        total++; if (avoid_count !== 16'd12) begin bad++; $display("FAIL bp_count got=%0d exp=12", avoid_count); end
    endtask

    task automatic accept_pwm_one(input logic clr, output bit ok);
        int budget = 0;
        pwm_in_valid = 1'b1;
        pwm_in_data = 16'h1234;
        while (!pwm_in_rdy && budget < 10) begin tick(); budget++; end
        ok = pwm_in_rdy;
        stat_clr = clr;
        tick();
        stat_clr = 1'b0;
        pwm_in_valid = 1'b0;
    endtask

    task automatic test_wrap_and_clear;
        int n = 0;
        int c = 0;
        bit acc, ok;
        do_reset();
        mon_en = 1'b0;
        pwm_in_valid = 1'b1;
        pwm_in_data = 16'h5555;
        while (n < 65535 && c < 70000) begin
            acc = pwm_in_rdy;
            tick();
            if (acc) n++;
            c++;
        end
        pwm_in_valid = 1'b0;
        total++; if (pwm_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset got=%h exp=ffff", pwm_count); end
        accept_pwm_one(1'b0, ok);
        total++; if (!ok || pwm_count !== 16'h0000) begin bad++; $display("FAIL wrap_to_zero got=%h rdy=%b exp=0000", pwm_count, ok); end
        accept_pwm_one(1'b0, ok);
        total++; if (!ok || pwm_count !== 16'h0001) begin bad++; $display("FAIL wrap_after got=%h rdy=%b exp=0001", pwm_count, ok); end
        accept_pwm_one(1'b1, ok);
        total++; if (!ok || pwm_count !== 16'h0000) begin bad++; $display("FAIL clr_wins got=%h rdy=%b exp=0000", pwm_count, ok); end
        total++; if (avoid_count !== 16'h0000) begin bad++; $display("FAIL clr_avoid got=%h exp=0000", avoid_count); end
    endtask

    task automatic test_reset_mid_burst;
        int n = 0;
        int c = 0;
        do_reset();
        while (n < 2 && c < 20) begin
            avoid_in_valid = 1'b1;
            avoid_in_data = 16'hD001 + 16'(n);
            #1;
            if (avoid_in_rdy) n++;
            tick();
            c++;
        end
        avoid_in_data = 16'hD003;
        pwm_in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (buf_out_valid !== 1'b0 || buf_out_data !== 16'h0 || buf_out_src !== 1'b0) begin
            bad++; $display("FAIL rstmid_out got=v%b d%h s%b exp=v0 d0000 s0", buf_out_valid, buf_out_data, buf_out_src);
        end
        total++; if (avoid_in_rdy !== 1'b0 || pwm_in_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_rdy got=%b%b exp=00", avoid_in_rdy, pwm_in_rdy); end
        total++; if (avoid_count !== 16'h0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", avoid_count); end
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        total++; if (avoid_in_rdy !== 1'b0 || pwm_in_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_first_cycle got=%b%b exp=00", avoid_in_rdy, pwm_in_rdy); end
        tick();
        total++; if (avoid_in_rdy !== 1'b1 || pwm_in_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_tie got=%b%b exp=10", avoid_in_rdy, pwm_in_rdy); end
        tick();
        total++; if (buf_out_valid !== 1'b1 || buf_out_data !== 16'hD003 || buf_out_src !== 1'b0) begin
            bad++; $display("FAIL rstmid_word got=v%b d%h s%b exp=v1 dd003 s0", buf_out_valid, buf_out_data, buf_out_src);
        end
        avoid_in_valid = 1'b0;
        pwm_in_valid = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_alternate();
        test_pwm_only();
        test_backpressure();
        test_wrap_and_clear();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
